// File: rtl/simmem_wdata_tracker_if.sv
// Write-address / write-data handshake bundle between requester, tracker and delay core.
interface simmem_wdata_tracker_if #(
    parameter int unsigned IidWidth      = 4,
    parameter int unsigned BurstLenWidth = 9
);
    logic                     waddr_valid_i;
    logic                     waddr_ready_o;
    logic [IidWidth-1:0]      waddr_iid_i;
    logic [BurstLenWidth-1:0] waddr_burst_len_i;
    logic                     wdata_valid_i;
    logic                     wdata_ready_o;
    logic                     wdata_last_i;
    logic                     core_waddr_valid_o;
    logic                     core_waddr_ready_i;
    logic [IidWidth-1:0]      core_waddr_iid_o;
    logic [BurstLenWidth-1:0] core_waddr_burst_len_o;
    logic [BurstLenWidth-1:0] core_wdata_immediate_cnt_o;
    logic                     core_wdata_valid_o;
    logic                     burst_done_o;
    logic [IidWidth-1:0]      burst_done_iid_o;
    logic                     wlast_err_o;

    modport master (
        output waddr_valid_i, waddr_iid_i, waddr_burst_len_i,
               wdata_valid_i, wdata_last_i, core_waddr_ready_i,
        input  waddr_ready_o, wdata_ready_o, core_waddr_valid_o,
               core_waddr_iid_o, core_waddr_burst_len_o,
               core_wdata_immediate_cnt_o, core_wdata_valid_o,
               burst_done_o, burst_done_iid_o, wlast_err_o
    );

    modport slave (
        input  waddr_valid_i, waddr_iid_i, waddr_burst_len_i,
               wdata_valid_i, wdata_last_i, core_waddr_ready_i,
        output waddr_ready_o, wdata_ready_o, core_waddr_valid_o,
               core_waddr_iid_o, core_waddr_burst_len_o,
               core_wdata_immediate_cnt_o, core_wdata_valid_o,
               burst_done_o, burst_done_iid_o, wlast_err_o
    );
endinterface

// File: rtl/simmem_wdata_tracker.sv
// Pairs snooped write-data beats with write-address bursts in arrival order.
// Optional WLAST consistency check enabled by defining SIMMEM_WLAST_CHECK_EN.
module simmem_wdata_tracker #(
    parameter int unsigned IidWidth      = 4,
    parameter int unsigned BurstLenWidth = 9,
    parameter int unsigned AddrFifoDepth = 8,
    parameter int unsigned MaxEarlyBeats = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    simmem_wdata_tracker_if.slave  io
);
    localparam int unsigned CntW = $clog2(MaxEarlyBeats + 1);
    localparam int unsigned LenW = BurstLenWidth + 1;
    localparam int unsigned AvW  = ((CntW > LenW) ? CntW : LenW) + 1;
    localparam int unsigned PtrW = $clog2(AddrFifoDepth);

    logic [CntW-1:0]          early_cnt_q;
    logic [CntW-1:0]          early_cnt_d;
    logic [IidWidth-1:0]      fifo_iid_q [AddrFifoDepth];
    logic [BurstLenWidth-1:0] fifo_rem_q [AddrFifoDepth];
    logic [PtrW-1:0]          rd_ptr_q;
    logic [PtrW-1:0]          wr_ptr_q;
    logic [PtrW:0]            occ_q;
    logic                     done_q;
    logic [IidWidth-1:0]      done_iid_q;

    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     waddr_ready;
    logic                     wdata_ready;
    logic                     hs_a;
    logic                     hs_d;
    logic                     beat_to_head;
    logic                     beat_to_cnt;
    logic [BurstLenWidth-1:0] head_rem;
    logic                     head_last;
    logic                     head_pop;
    logic [LenW-1:0]          len_ext;
    logic [AvW-1:0]           avail;
    logic [LenW-1:0]          imm;
    logic [LenW-1:0]          rem_new;
    logic                     push;
    logic                     addr_done;

    // Ready decisions use only registered occupancy, so a same-cycle pop never bypasses into a push.
    assign fifo_empty   = (occ_q == '0);
    assign fifo_full    = (occ_q == (PtrW+1)'(AddrFifoDepth));
    assign waddr_ready  = io.core_waddr_ready_i && !fifo_full;
    assign hs_a         = io.waddr_valid_i && waddr_ready;
    assign wdata_ready  = !fifo_empty || (early_cnt_q < CntW'(MaxEarlyBeats)) || hs_a;
    assign hs_d         = io.wdata_valid_i && wdata_ready;

    assign beat_to_head = hs_d && !fifo_empty;
    assign beat_to_cnt  = hs_d && fifo_empty;
    assign head_rem     = fifo_rem_q[rd_ptr_q];
    assign head_last    = (head_rem == BurstLenWidth'(1));
    assign head_pop     = beat_to_head && head_last;

    // A zero length is illegal; treating it as one beat keeps the pairing consistent.
    assign len_ext   = (io.waddr_burst_len_i == '0) ? LenW'(1) : {1'b0, io.waddr_burst_len_i};
    assign avail     = AvW'(early_cnt_q) + AvW'(beat_to_cnt);
    assign imm       = (avail < AvW'(len_ext)) ? LenW'(avail) : len_ext;
    assign rem_new   = len_ext - imm;
    assign push      = hs_a && (rem_new != '0);
    assign addr_done = hs_a && (rem_new == '0);

    always_comb begin
        early_cnt_d = early_cnt_q;
        if (hs_a) begin
            early_cnt_d = CntW'(avail - AvW'(imm));
        end else if (beat_to_cnt) begin
            early_cnt_d = early_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            early_cnt_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
            done_q      <= 1'b0;
            done_iid_q  <= '0;
        end else begin
            early_cnt_q <= early_cnt_d;
            if (head_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push)     wr_ptr_q <= wr_ptr_q + PtrW'(1);
            case ({push, head_pop})
                2'b10:   occ_q <= occ_q + (PtrW+1)'(1);
                2'b01:   occ_q <= occ_q - (PtrW+1)'(1);
                default: occ_q <= occ_q;
            endcase
            done_q <= head_pop || addr_done;
            if (head_pop) begin
                done_iid_q <= fifo_iid_q[rd_ptr_q];
            end else if (addr_done) begin
                done_iid_q <= io.waddr_iid_i;
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (beat_to_head && !head_last) begin
            fifo_rem_q[rd_ptr_q] <= head_rem - BurstLenWidth'(1);
        end
        if (push) begin
            fifo_iid_q[wr_ptr_q] <= io.waddr_iid_i;
            fifo_rem_q[wr_ptr_q] <= rem_new[BurstLenWidth-1:0];
        end
    end

`ifdef SIMMEM_WLAST_CHECK_EN
    logic wlast_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wlast_err_q <= 1'b0;
        end else if (beat_to_head && (io.wdata_last_i != head_last)) begin
            wlast_err_q <= 1'b1;
        end
    end

    assign io.wlast_err_o = wlast_err_q;
`else
    logic unused_wdata_last;
    assign unused_wdata_last = io.wdata_last_i;
    assign io.wlast_err_o    = 1'b0;
`endif

    assign io.waddr_ready_o              = waddr_ready;
    assign io.wdata_ready_o              = wdata_ready;
    assign io.core_waddr_valid_o         = io.waddr_valid_i && !fifo_full;
    assign io.core_waddr_iid_o           = io.waddr_iid_i;
    assign io.core_waddr_burst_len_o     = io.waddr_burst_len_i;
    assign io.core_wdata_immediate_cnt_o = hs_a ? imm[BurstLenWidth-1:0] : '0;
    assign io.core_wdata_valid_o         = beat_to_head;
    assign io.burst_done_o               = done_q;
    assign io.burst_done_iid_o           = done_iid_q;

    a_len_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        io.waddr_valid_i |-> (io.waddr_burst_len_i != '0));

    a_early_only_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (early_cnt_q != '0) |-> fifo_empty);
endmodule
